// File: rtl/udm_bus_arb.sv
// udm_bus_arb: two-master round-robin arbiter onto one system-bus slave, read IDs tracked in a FIFO.
// One registered grant cycle per command, ack/resp combinational; reads held while the ID FIFO is full.
module udm_bus_arb #(
  parameter int RD_OUTSTANDING = 4,
  parameter int HRESET_CLR     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hreset_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [3:0]  m0_be_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [3:0]  m1_be_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_bo,
  output logic [3:0]  s_be_bo,
  output logic [31:0] s_wdata_bo,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_bi,
  output logic        busy_o
);

  localparam int CW = $clog2(RD_OUTSTANDING) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          prio, prio_nxt;
  logic          err;
  logic          flush, gnt, sel;
  logic          g_req, g_we, other_req;
  logic [31:0]   g_addr, g_wdata;
  logic [3:0]    g_be;
  logic          stall, accept, push, pop_vld;
  logic          fifo_full, fifo_empty, head_id;
  logic [CW-1:0] fifo_cnt;

  assign flush = (HRESET_CLR != 0) && hreset_i;
  assign gnt   = (state != IDLE);
  assign sel   = (state == GNT1);

  assign g_req     = sel ? m1_req_i    : m0_req_i;
  assign g_we      = sel ? m1_we_i     : m0_we_i;
  assign g_addr    = sel ? m1_addr_bi  : m0_addr_bi;
  assign g_be      = sel ? m1_be_bi    : m0_be_bi;
  assign g_wdata   = sel ? m1_wdata_bi : m0_wdata_bi;
  assign other_req = sel ? m0_req_i    : m1_req_i;

  // A same-cycle pop frees a slot, so a read may be pushed even when full.
  assign pop_vld = s_resp_i & ~fifo_empty;
  assign stall   = fifo_full & ~pop_vld & ~g_we;

  assign s_req_o    = gnt & g_req & ~stall;
  assign s_we_o     = gnt & g_we;
  assign s_addr_bo  = gnt ? g_addr  : '0;
  assign s_be_bo    = gnt ? g_be    : '0;
  assign s_wdata_bo = gnt ? g_wdata : '0;

  assign accept   = s_req_o & s_ack_i;
  assign push     = accept & ~g_we;
  assign m0_ack_o = accept & ~sel;
  assign m1_ack_o = accept & sel;

  assign m0_resp_o   = pop_vld & ~head_id;
  assign m1_resp_o   = pop_vld & head_id;
  assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
  assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

  assign busy_o = gnt | (fifo_cnt != '0);

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    case (state)
      IDLE: begin
        if (m0_req_i && m1_req_i) state_nxt = prio ? GNT1 : GNT0;
        else if (m0_req_i)        state_nxt = GNT0;
        else if (m1_req_i)        state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        // Grant stays locked until accept; then hand straight over if the other master waits.
        if (accept) begin
          prio_nxt  = ~sel;
          state_nxt = other_req ? (sel ? GNT0 : GNT1) : IDLE;
        end else if (!g_req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  // Response with no read outstanding is a protocol error; sticky until rst_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      err <= 1'b0;
    else if (s_resp_i & fifo_empty) err <= 1'b1;
  end

  udm_fifo #(.W(1), .DEPTH(RD_OUTSTANDING)) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .flush    (flush),
    .push     (push),
    .push_dat (sel),
    .pop      (s_resp_i),
    .pop_dat  (head_id),
    .count    (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// udm_fifo: small generic FIFO with registered pointers and a synchronous flush.
// Head data combinational; push while full is dropped unless a pop frees the slot in the same cycle.
module udm_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + ONE;
      else if (pop_ok && !push_ok) count <= count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: tb/tb_udm_bus_arb.sv
// Bench for udm_bus_arb: scripted masters and slave, read routing checked against a response scoreboard.
`timescale 1ns/1ps
module tb_udm_bus_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hreset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_be = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_be = '0;
  logic        m0_ack, m0_resp, m1_ack, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_ack = 1'b0, s_resp = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        busy;

  typedef struct { logic id; logic [31:0] data; } rd_t;
  rd_t exp_q[$];
  bit  exp_gnt[$];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  udm_bus_arb #(.RD_OUTSTANDING(4), .HRESET_CLR(1)) dut (
    .clk_i(clk), .rst_i(rst), .hreset_i(hreset),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_be_bi(m0_be),
    .m0_wdata_bi(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_be_bi(m1_be),
    .m1_wdata_bi(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be), .s_wdata_bo(s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {m0_ack, m1_ack, m0_resp, m1_resp, s_req, s_we, busy, s_be}, 64'h0);
    check({tag, "_addr_wdata"}, {s_addr, s_wdata}, 64'h0);
    check({tag, "_rdata"}, {m0_rdata, m1_rdata}, 64'h0);
  endtask

  // Slave returns the oldest scoreboard entry; the issuing master alone must see it.
  task automatic slave_resp(input string tag);
    rd_t e;
    step();
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    s_resp = 1'b1;
    s_rdata = e.data;
    #2;
    check({tag, "_resp"}, {m1_resp, m0_resp}, e.id ? 2'b10 : 2'b01);
    check({tag, "_rdata"}, {m1_rdata, m0_rdata}, e.id ? {e.data, 32'h0} : {32'h0, e.data});
    step();
    s_resp = 1'b0;
  endtask

  task automatic issue(input bit m, input bit we, input logic [31:0] addr, input string tag);
    bit got = 1'b0;
    step();
    if (m) begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_be = 4'hf; end
    else   begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_be = 4'hf; end
    s_ack = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      #2;
      if (m ? m1_ack : m0_ack) got = 1'b1;
    end
    check({tag, "_ack"}, got, 1);
    step();
    m0_req = 1'b0;
    m1_req = 1'b0;
    s_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int  n0, n1, acc;
    bit  g;
    rd_t e;

    #3;
    check_quiet("reset");
    check("reset_state", {dut.state, dut.prio, dut.err}, 0);
    rst = 1'b0;

    // Single master 0 write, slave acks two cycles after the command appears
    step();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h8000_0000; m0_be = 4'hf; m0_wdata = 32'h1122_33cc;
    #2;
    check("t1_arb_latency", s_req, 0);
    step(); #2;
    check("t1_sreq", {s_req, s_we}, 2'b11);
    check("t1_saddr", s_addr, 32'h8000_0000);
    check("t1_swdata", {s_wdata, s_be}, {32'h1122_33cc, 4'hf});
    check("t1_wait0", {m0_ack, m1_ack}, 0);
    step(); #2;
    check("t1_wait1", {m0_ack, m1_ack}, 0);
    step();
    s_ack = 1'b1;
    #2;
    check("t1_ack", {m1_ack, m0_ack}, 2'b01);
    step();
    m0_req = 1'b0; s_ack = 1'b0;
    #2;
    check("t1_ack_once", {m0_ack, m1_ack, s_req}, 0);

    step();
    rst = 1'b1;
    #2;
    rst = 1'b0;

    // Both masters request continuously; grants must alternate starting at master 0
    step();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0010;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8000_0020; m1_be = 4'h3;
    s_ack = 1'b1;
    for (int i = 0; i < 8; i++) exp_gnt.push_back(i[0]);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(); #2;
      g = exp_gnt.pop_front();
      check("t2_grant", {m1_ack, m0_ack}, g ? 2'b10 : 2'b01);
      check("t2_addr", s_addr, g ? 32'h8000_0020 : 32'h0000_0010);
      n0 += int'(m0_ack);
      n1 += int'(m1_ack);
    end
    check("t2_cnt0", n0, 4);
    check("t2_cnt1", n1, 4);
    step();
    m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;

    // One read from each master, responses routed back in order
    step();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0004;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8000_0024;
    s_ack = 1'b1;
    exp_q.push_back('{1'b0, 32'h0000_0030});
    exp_q.push_back('{1'b1, 32'hdead_beef});
    step(); #2;
    check("t3_ack0", {m1_ack, m0_ack}, 2'b01);
    check("t3_addr0", s_addr, 32'h0000_0004);
    step();
    m0_req = 1'b0;
    #2;
    check("t3_ack1", {m1_ack, m0_ack}, 2'b10);
    check("t3_addr1", s_addr, 32'h8000_0024);
    step();
    m1_req = 1'b0; s_ack = 1'b0;
    #2;
    check("t3_busy", busy, 1);
    slave_resp("t3_first");
    slave_resp("t3_second");
    #2;
    check("t3_idle", busy, 0);

    // Master 1 fills the ID FIFO; the fifth read waits for a response
    for (int i = 0; i < 5; i++) exp_q.push_back('{1'b1, 32'h100 + i});
    step();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8000_0040; s_ack = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && acc < 4; i++) begin
      step(); #2;
      if (s_req && s_ack) begin
        check("t4_ack", m1_ack, 1);
        acc++;
      end
    end
    check("t4_accepted4", acc, 4);
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      check("t4_stall", {s_req, m1_ack}, 0);
    end
    check("t4_busy", busy, 1);
    step();
    e = exp_q.pop_front();
    s_resp = 1'b1; s_rdata = e.data;
    #2;
    check("t4_unstall", s_req, 1);
    check("t4_ack5", m1_ack, 1);
    check("t4_resp", {m1_resp, m0_resp}, 2'b10);
    check("t4_rdata", {m1_rdata, m0_rdata}, {e.data, 32'h0});
    step();
    s_resp = 1'b0; m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0008; m0_wdata = 32'h0000_00a5;
    step(); #2;
    check("t4_full", dut.fifo_full, 1);
    check("t4_wr_full", {s_req, m0_ack}, 2'b11);
    step();
    m0_req = 1'b0; s_ack = 1'b0;
    for (int i = 0; i < 4; i++) slave_resp("t4_drain");
    #2;
    check("t4_drained", busy, 0);

    // Debug flush with two reads outstanding
    issue(1'b0, 1'b0, 32'h0000_000c, "t5_rd_a");
    issue(1'b0, 1'b0, 32'h0000_0010, "t5_rd_b");
    #2;
    check("t5_busy_pre", busy, 1);
    check("t5_err_pre", dut.err, 0);
    step();
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    #2;
    check("t5_busy_flush", busy, 0);
    check("t5_prio_flush", dut.prio, 0);
    step();
    s_resp = 1'b1; s_rdata = 32'h0000_0055;
    #2;
    check("t5_dropped", {m1_resp, m0_resp, m1_rdata, m0_rdata}, 0);
    step();
    s_resp = 1'b0;
    #2;
    check("t5_err", dut.err, 1);

    // Async reset while master 1 waits for an ack
    issue(1'b0, 1'b1, 32'h0000_0014, "t6_wr");
    step();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8000_0044; m1_wdata = 32'hcafe_0001; m1_be = 4'hf;
    step(); #2;
    check("t6_pending", {s_req, s_we, m1_ack}, 3'b110);
    check("t6_prio_pre", dut.prio, 1);
    rst = 1'b1;
    #1;
    check_quiet("t6_in_reset");
    #1;
    rst = 1'b0;
    #1;
    check("t6_state_prio", {dut.state, dut.prio, dut.err}, 0);
    m1_req = 1'b0;
    step(); #2;
    check_quiet("t6_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
